// File: rtl/axis_tx_hdr_insert.sv
// axis_tx_hdr_insert
// Prepends one header beat (magic, sequence number, declared length) to each
// AXIS payload frame, then passes the payload through with zero latency.
// Counts payload bytes and flags frames whose byte count differs from the
// declared size.
//
// Handshake semantics (both ports): a beat transfers on a rising clk edge
// where tvalid and tready are both 1; once tvalid is raised, tdata/tkeep/tlast
// stay stable and tvalid stays high until that transfer. tvalid never depends
// on tready; in PAYLOAD s_axis_tready follows m_axis_tready combinationally.

module axis_tx_hdr_insert #(
   parameter int          AXIS_DATA_WIDTH = 64,
   parameter int          LEN_WIDTH       = 16,
   parameter logic [15:0] HDR_MAGIC       = 16'hA55A
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [LEN_WIDTH-1:0]         s_size,
   input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                         s_axis_tvalid,
   input  logic                         s_axis_tlast,
   output logic                         s_axis_tready,
   output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                         m_axis_tvalid,
   output logic                         m_axis_tlast,
   input  logic                         m_axis_tready,
   output logic [15:0]                  frame_seq,
   output logic                         len_err,
   output logic [15:0]                  err_cnt,
   output logic [1:0]                   fsm_state
);

   localparam int KEEP_W = AXIS_DATA_WIDTH / 8;
   localparam int POP_W  = $clog2(KEEP_W + 1);
   localparam int CNT_W  = LEN_WIDTH + 1;
   localparam int SUM_W  = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
   localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR     = 2'd1,
      ST_PAYLOAD = 2'd2
   } state_t;

   state_t                       state;
   logic [LEN_WIDTH-1:0]         size_q;
   logic [CNT_W-1:0]             byte_cnt;
   logic [15:0]                  seq_q;
   logic [AXIS_DATA_WIDTH-1:0]   hdr_data_q;
   logic [KEEP_W-1:0]            hdr_keep_q;
   logic                         hdr_valid_q;

   logic                         in_payload;
   logic                         payload_hs;
   logic [POP_W-1:0]             beat_bytes;
   logic [SUM_W-1:0]             cnt_sum;
   logic [CNT_W-1:0]             cnt_next;
   logic                         size_mismatch;
   logic [AXIS_DATA_WIDTH-1:0]   hdr_word;

   function automatic logic [POP_W-1:0] popcount(input logic [KEEP_W-1:0] v);
      logic [POP_W-1:0] n;
      n = '0;
      for (int i = 0; i < KEEP_W; i++) begin
         n = n + {{(POP_W-1){1'b0}}, v[i]};
      end
      return n;
   endfunction

   assign in_payload = (state == ST_PAYLOAD);
   assign payload_hs = in_payload & s_axis_tvalid & m_axis_tready;
   assign frame_seq  = seq_q;
   assign fsm_state  = state;

   // Payload is a straight combinational pass-through; otherwise the header registers drive the port.
   always_comb begin
      m_axis_tdata  = hdr_data_q;
      m_axis_tkeep  = hdr_keep_q;
      m_axis_tvalid = hdr_valid_q;
      m_axis_tlast  = 1'b0;
      s_axis_tready = 1'b0;
      if (in_payload) begin
         m_axis_tdata  = s_axis_tdata;
         m_axis_tkeep  = s_axis_tkeep;
         m_axis_tvalid = s_axis_tvalid;
         m_axis_tlast  = s_axis_tlast;
         s_axis_tready = m_axis_tready;
      end
   end

   // Running byte total including the current beat, saturating instead of wrapping.
   always_comb begin
      beat_bytes    = popcount(s_axis_tkeep);
      cnt_sum       = {{(SUM_W-CNT_W){1'b0}}, byte_cnt} + {{(SUM_W-POP_W){1'b0}}, beat_bytes};
      cnt_next      = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
      size_mismatch = (cnt_next != {1'b0, size_q});
   end

   // Header word assembled from the live size and sequence at frame detect.
   always_comb begin
      hdr_word        = '0;
      hdr_word[63:0]  = {16'h0000, HDR_MAGIC, seq_q, 16'(s_size)};
   end

   // Frame FSM: detect, emit header, forward payload, then check length and advance sequence.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         size_q      <= '0;
         byte_cnt    <= '0;
         seq_q       <= '0;
         hdr_data_q  <= '0;
         hdr_keep_q  <= '0;
         hdr_valid_q <= 1'b0;
         len_err     <= 1'b0;
         err_cnt     <= '0;
      end else begin
         len_err <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (s_axis_tvalid) begin
                  size_q      <= s_size;
                  hdr_data_q  <= hdr_word;
                  hdr_keep_q  <= '1;
                  hdr_valid_q <= 1'b1;
                  state       <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (m_axis_tready) begin
                  hdr_data_q  <= '0;
                  hdr_keep_q  <= '0;
                  hdr_valid_q <= 1'b0;
                  byte_cnt    <= '0;
                  state       <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (payload_hs) begin
                  byte_cnt <= cnt_next;
                  if (s_axis_tlast) begin
                     if (size_mismatch) begin
                        len_err <= 1'b1;
                        if (err_cnt != 16'hFFFF) begin
                           err_cnt <= err_cnt + 16'd1;
                        end
                     end
                     seq_q <= seq_q + 16'd1;
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_tx_hdr_insert.sv
// Bench for axis_tx_hdr_insert: random frames plus directed cases, checked
// against a frame-level reference model (expected beat queue, per-frame
// length-error bit, sequence and error counters).

module tb_axis_tx_hdr_insert;

   logic         clk = 1'b0;
   logic         rstn;
   logic [15:0]  s_size;
   logic [63:0]  s_axis_tdata;
   logic [7:0]   s_axis_tkeep;
   logic         s_axis_tvalid;
   logic         s_axis_tlast;
   logic         s_axis_tready;
   logic [63:0]  m_axis_tdata;
   logic [7:0]   m_axis_tkeep;
   logic         m_axis_tvalid;
   logic         m_axis_tlast;
   logic         m_axis_tready = 1'b1;
   logic [15:0]  frame_seq;
   logic         len_err;
   logic [15:0]  err_cnt;
   logic [1:0]   fsm_state;

   int tests = 0;
   int fails = 0;

   // bench control (written by the main sequence only)
   logic         bp_on = 1'b0;
   logic         mon_en = 1'b0;
   logic         check_gap = 1'b0;
   logic [15:0]  drv_seq;
   int           seq_load_id = 0;
   logic [15:0]  seq_load_val = 16'h0;
   int           mdl_reset_id = 0;

   // reference model state (written by the monitor only)
   logic [73:0]  exp_q[$];      // {is_hdr, tlast, tkeep, tdata}
   logic         exp_err_q[$];
   logic [15:0]  mdl_seq = 16'h0;
   logic [15:0]  mdl_err = 16'h0;
   logic         mdl_len_err = 1'b0;
   logic [63:0]  cap_hdr = 64'h0;
   int           pulse_cnt = 0;

   axis_tx_hdr_insert dut (
      .clk           (clk),
      .rstn          (rstn),
      .s_size        (s_size),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .frame_seq     (frame_seq),
      .len_err       (len_err),
      .err_cnt       (err_cnt),
      .fsm_state     (fsm_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // downstream ready: always ready, or a 50% coin toss per cycle
   always @(posedge clk) begin
      #1;
      m_axis_tready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // ---------------- monitor / scoreboard ----------------
   int          seq_load_seen = 0;
   int          reset_seen = 0;
   logic        held = 1'b0;
   logic [72:0] held_val = '0;
   logic        gap_armed = 1'b0;
   int          gap = 0;

   always @(negedge clk) begin
      logic [73:0] e;
      logic        err_bit;
      logic        exp_sr;
      if (reset_seen != mdl_reset_id) begin
         reset_seen  = mdl_reset_id;
         mdl_seq     = 16'h0;
         mdl_err     = 16'h0;
         mdl_len_err = 1'b0;
         held        = 1'b0;
         gap_armed   = 1'b0;
         exp_q.delete();
         exp_err_q.delete();
      end
      if (seq_load_seen != seq_load_id) begin
         seq_load_seen = seq_load_id;
         mdl_seq       = seq_load_val;
      end
      if (mon_en) begin
         chk("frame_seq", frame_seq, mdl_seq);
         chk("err_cnt", err_cnt, mdl_err);
         chk("len_err", len_err, mdl_len_err);
         if (len_err) pulse_cnt++;
         exp_sr = (exp_q.size() > 0 && !exp_q[0][73]) ? m_axis_tready : 1'b0;
         chk("s_tready", s_axis_tready, exp_sr);
         if (held) begin
            chk("hold_valid", m_axis_tvalid, 1'b1);
            chk("hold_beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, held_val);
         end
         held     = m_axis_tvalid && !m_axis_tready;
         held_val = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
         if (gap_armed && m_axis_tvalid) begin
            if (check_gap) chk("idle_gap", gap, 1);
            gap_armed = 1'b0;
         end else if (gap_armed) begin
            gap++;
         end
         mdl_len_err = 1'b0;
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 73'h0);
            end else begin
               e = exp_q.pop_front();
               chk("out_beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, e[72:0]);
               if (e[73]) cap_hdr = m_axis_tdata;
               if (e[72]) begin
                  err_bit = (exp_err_q.size() > 0) ? exp_err_q.pop_front() : 1'b0;
                  mdl_len_err = err_bit;
                  if (err_bit && mdl_err != 16'hFFFF) mdl_err = mdl_err + 16'd1;
                  mdl_seq   = mdl_seq + 16'd1;
                  gap_armed = 1'b1;
                  gap       = 0;
               end
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends one frame; returns at posedge+1 right after its last beat is taken.
   task automatic send_frame(input int nbeats, input logic [7:0] last_keep, input logic [15:0] size);
      logic [63:0] d[$];
      logic [7:0]  k[$];
      int          bytes;
      int          idx;
      int          guard;
      logic        hs;
      bytes = 0;
      for (int i = 0; i < nbeats; i++) begin
         d.push_back({$urandom, $urandom});
         k.push_back((i == nbeats - 1) ? last_keep : 8'hFF);
         bytes += $countones(k[i]);
      end
      exp_q.push_back({1'b1, 1'b0, 8'hFF, 16'h0000, 16'hA55A, drv_seq, size});
      for (int i = 0; i < nbeats; i++) begin
         exp_q.push_back({1'b0, (i == nbeats - 1), k[i], d[i]});
      end
      exp_err_q.push_back(bytes != int'(size));
      drv_seq = drv_seq + 16'd1;
      s_size        = size;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d[0];
      s_axis_tkeep  = k[0];
      s_axis_tlast  = (nbeats == 1);
      idx   = 0;
      guard = 0;
      while (idx < nbeats && guard < 2000) begin
         @(negedge clk);
         hs = s_axis_tvalid && s_axis_tready;
         @(posedge clk);
         #1;
         guard++;
         s_size = 16'($urandom);   // must be ignored once latched
         if (hs) begin
            idx++;
            if (idx < nbeats) begin
               s_axis_tdata = d[idx];
               s_axis_tkeep = k[idx];
               s_axis_tlast = (idx == nbeats - 1);
            end else begin
               s_axis_tvalid = 1'b0;
               s_axis_tlast  = 1'b0;
            end
         end
      end
      chk("frame_done", idx, nbeats);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int   n;
      int   guard;
      int   p0;
      logic hs;
      int   nb;
      int   kb;
      int   bytes;
      logic [7:0]  lk;
      logic [15:0] sz;
      logic b2b;

      rstn = 1'b0;
      s_size = '0; s_axis_tdata = '0; s_axis_tkeep = '0;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      drv_seq = 16'h0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_m_tdata", m_axis_tdata, 0);
      chk("rst_m_tkeep", m_axis_tkeep, 0);
      chk("rst_m_tlast", m_axis_tlast, 0);
      chk("rst_s_tready", s_axis_tready, 0);
      chk("rst_frame_seq", frame_seq, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_len_err", len_err, 0);
      chk("rst_state", fsm_state, 0);
      @(posedge clk); #1;
      rstn = 1'b1;
      mon_en = 1'b1;
      idle(2);

      // single 20-byte frame
      p0 = pulse_cnt;
      send_frame(3, 8'h0F, 16'd20);
      idle(3);
      chk("single_hdr", cap_hdr, 64'h0000_A55A_0000_0014);
      chk("single_seq", frame_seq, 1);
      chk("single_err_cnt", err_cnt, 0);
      chk("single_no_pulse", pulse_cnt - p0, 0);

      // declared 24, sent 20
      p0 = pulse_cnt;
      send_frame(3, 8'h0F, 16'd24);
      idle(3);
      chk("mismatch_pulses", pulse_cnt - p0, 1);
      chk("mismatch_err_cnt", err_cnt, 1);
      chk("mismatch_seq", frame_seq, 2);

      // 10-beat frame under random backpressure
      bp_on = 1'b1;
      send_frame(10, 8'h0F, 16'd76);
      bp_on = 1'b0;
      idle(3);
      chk("bp_err_cnt", err_cnt, 1);

      // three frames back to back with tvalid held high
      check_gap = 1'b0;
      send_frame(2, 8'hFF, 16'd16);
      check_gap = 1'b1;
      send_frame(1, 8'h07, 16'd3);
      send_frame(3, 8'h01, 16'd17);
      check_gap = 1'b0;
      idle(3);
      chk("b2b_seq", frame_seq, 6);

      // zero-size one-beat frames
      send_frame(1, 8'h00, 16'd0);
      idle(2);
      chk("zero_ok_err_cnt", err_cnt, 1);
      send_frame(1, 8'h03, 16'd0);
      idle(2);
      chk("zero_bad_hdr_len", cap_hdr[15:0], 16'h0000);
      chk("zero_bad_err_cnt", err_cnt, 2);

      // random frames
      for (int f = 0; f < 30; f++) begin
         nb = $urandom_range(1, 6);
         kb = $urandom_range(0, 8);
         lk = 8'((16'd1 << kb) - 16'd1);
         bytes = 8 * (nb - 1) + kb;
         sz = ($urandom_range(0, 3) == 0) ? 16'(bytes + $urandom_range(1, 3)) : 16'(bytes);
         bp_on = 1'($urandom_range(0, 1));
         b2b = ($urandom_range(0, 2) == 0);
         check_gap = b2b;
         if (!b2b) idle($urandom_range(0, 3));
         send_frame(nb, lk, sz);
      end
      bp_on = 1'b0;
      check_gap = 1'b0;
      idle(4);

      // sequence wrap
      force dut.seq_q = 16'hFFFF;
      seq_load_val = 16'hFFFF;
      seq_load_id++;
      drv_seq = 16'hFFFF;
      @(posedge clk); #1;
      release dut.seq_q;
      idle(1);
      send_frame(2, 8'hFF, 16'd16);
      idle(3);
      chk("wrap_hdr_seq", cap_hdr[31:16], 16'hFFFF);
      chk("wrap_frame_seq", frame_seq, 0);

      // asynchronous reset during payload beat 2 of 5
      idle(2);
      mon_en = 1'b0;
      s_size = 16'd40;
      s_axis_tvalid = 1'b1;
      s_axis_tdata = {$urandom, $urandom};
      s_axis_tkeep = 8'hFF;
      s_axis_tlast = 1'b0;
      n = 0;
      guard = 0;
      while (n < 2 && guard < 100) begin
         @(negedge clk);
         hs = s_axis_tvalid && s_axis_tready && fsm_state == 2'd2;
         @(posedge clk); #1;
         guard++;
         if (hs) begin
            n++;
            s_axis_tdata = {$urandom, $urandom};
         end
      end
      chk("rst_setup_beats", n, 2);
      @(negedge clk);
      chk("rst_pre_valid", m_axis_tvalid, 1);
      rstn = 1'b0;
      #1;
      chk("midrst_m_tvalid", m_axis_tvalid, 0);
      chk("midrst_m_tdata", m_axis_tdata, 0);
      chk("midrst_m_tkeep", m_axis_tkeep, 0);
      chk("midrst_m_tlast", m_axis_tlast, 0);
      chk("midrst_s_tready", s_axis_tready, 0);
      chk("midrst_frame_seq", frame_seq, 0);
      chk("midrst_err_cnt", err_cnt, 0);
      chk("midrst_len_err", len_err, 0);
      chk("midrst_state", fsm_state, 0);
      s_axis_tvalid = 1'b0;
      s_axis_tkeep = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      mdl_reset_id++;
      drv_seq = 16'h0;
      mon_en = 1'b1;
      idle(2);

      // the restarted frame reuses the abandoned frame's sequence number
      send_frame(2, 8'h01, 16'd9);
      idle(3);
      chk("restart_hdr_seq", cap_hdr[31:16], 16'h0000);
      chk("restart_frame_seq", frame_seq, 1);
      chk("restart_err_cnt", err_cnt, 0);

      idle(3);
      chk("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
